cacheline_adaptor: RTL

- Sits directly downstream of the memory arbiter. Accepts its single 256-bit line read/write request and converts it to a 4-beat, 64-bit burst transaction on the physical DRAM interface.
- Assembles read beats into a line, or serialises a write line into beats.
- Returns a one-cycle completion pulse to the arbiter.

---
 rtl/cacheline_pkg.sv | 22 ++
 rtl/cacheline_adaptor.sv | 90 +++++++++
 2 files changed

// File: rtl/cacheline_pkg.sv
// Shared types and sizing for the line-to-burst adaptor.
package cacheline_pkg;

    localparam int BEAT_WIDTH  = 64;
    localparam int BEATS       = 4;
    localparam int LINE_WIDTH  = BEAT_WIDTH * BEATS;
    localparam int OFFSET_BITS = 5;

    localparam logic [31:0] LINE_OFFSET_MASK = 32'((1 << OFFSET_BITS) - 1);

    typedef logic [LINE_WIDTH-1:0]    line_t;
    typedef logic [BEAT_WIDTH-1:0]    beat_t;
    typedef logic [$clog2(BEATS)-1:0] count_t;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } adaptor_state_t;

endpackage

// File: rtl/cacheline_adaptor.sv
// Converts one 256-bit line read/write into a 4-beat 64-bit DRAM burst.
// Request to resp_o is 6 cycles minimum; DRAM resp_i gaps simply stall the beat count.
module cacheline_adaptor
    import cacheline_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  line_t       line_i,
    output line_t       line_o,
    input  logic [31:0] address_i,
    input  logic        read_i,
    input  logic        write_i,
    output logic        resp_o,
    input  beat_t       burst_i,
    output beat_t       burst_o,
    output logic [31:0] address_o,
    output logic        read_o,
    output logic        write_o,
    input  logic        resp_i
);

    adaptor_state_t state;
    count_t         count;
    line_t          wline;

    localparam count_t LAST_BEAT = count_t'(BEATS - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            wline     <= '0;
            line_o    <= '0;
            address_o <= '0;
            read_o    <= 1'b0;
            write_o   <= 1'b0;
            resp_o    <= 1'b0;
        end else begin
            resp_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    // Read has priority when the arbiter raises both.
                    if (read_i) begin
                        state     <= READ;
                        count     <= '0;
                        address_o <= address_i & ~LINE_OFFSET_MASK;
                        read_o    <= 1'b1;
                    end else if (write_i) begin
                        state     <= WRITE;
                        count     <= '0;
                        address_o <= address_i & ~LINE_OFFSET_MASK;
                        wline     <= line_i;
                        write_o   <= 1'b1;
                    end
                end
                READ: begin
                    if (resp_i) begin
                        line_o[count*BEAT_WIDTH +: BEAT_WIDTH] <= burst_i;
                        count <= count + count_t'(1);
                        if (count == LAST_BEAT) begin
                            read_o <= 1'b0;
                            resp_o <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                WRITE: begin
                    if (resp_i) begin
                        count <= count + count_t'(1);
                        if (count == LAST_BEAT) begin
                            write_o <= 1'b0;
                            resp_o  <= 1'b1;
                            state   <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The beat on the bus tracks the count directly so beat 0 is present on the first WRITE cycle.
    assign burst_o = (state == WRITE) ? wline[count*BEAT_WIDTH +: BEAT_WIDTH] : '0;

endmodule
